// File: rtl/axi_cfg_seq_pkg.sv
// Shared definitions for the AXI4-Lite configuration sequencer: table op codes,
// FSM state encoding, table entry field offsets and AXI response codes.
package axi_cfg_seq_pkg;

  // Table entry op codes, stored in the top two bits of every entry.
  typedef enum logic [1:0] {
    OP_END   = 2'b00,
    OP_WRITE = 2'b01,
    OP_POLL  = 2'b10,
    OP_WAIT  = 2'b11
  } op_e;

  // Sequencer FSM states.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_WR_REQ = 4'd3,
    ST_WR_RSP = 4'd4,
    ST_RD_REQ = 4'd5,
    ST_RD_RSP = 4'd6,
    ST_WAIT   = 4'd7,
    ST_NEXT   = 4'd8,
    ST_FINISH = 4'd9,
    ST_ERR    = 4'd10
  } state_e;

  // Entry layout {op, addr, data, mask}; data and mask are always 32 bits,
  // so only the op offset depends on the address width.
  localparam int ENT_MASK_LSB = 0;
  localparam int ENT_DATA_LSB = 32;
  localparam int ENT_ADDR_LSB = 64;

  // WAIT entries use the low 16 bits of the data field as a cycle count.
  localparam int WAIT_W = 16;

  localparam logic [1:0] AXI_OKAY = 2'b00;

endpackage

// File: rtl/axi_cfg_sequencer.sv
// Table-driven AXI4-Lite master. Walks a command table held in an external
// synchronous ROM (1-cycle read latency) and executes WRITE, POLL-until-match
// (with timeout) and WAIT entries, reporting done and a sticky error.
//
// Handshake: a transfer on any AXI channel happens on a rising edge where both
// valid and ready are high. Valids are never withdrawn before their handshake,
// address/data are held stable while valid is high, and only one transaction
// is outstanding at a time. bready/rready are high only in the response states.
module axi_cfg_sequencer
  import axi_cfg_seq_pkg::*;
#(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 32,
  parameter int TBL_AW       = 6,
  parameter int POLL_TIMEOUT = 1024,
  localparam int ENTRY_W     = 2 + ADDR_W + 2 * DATA_W
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [TBL_AW-1:0]  err_idx_o,
  output logic [TBL_AW-1:0]  tbl_addr_o,
  input  logic [ENTRY_W-1:0] tbl_data_i,
  output logic [ADDR_W-1:0]  m_axi_awaddr,
  output logic [2:0]         m_axi_awprot,
  output logic               m_axi_awvalid,
  input  logic               m_axi_awready,
  output logic [DATA_W-1:0]  m_axi_wdata,
  output logic [3:0]         m_axi_wstrb,
  output logic               m_axi_wlast,
  output logic               m_axi_wvalid,
  input  logic               m_axi_wready,
  input  logic [1:0]         m_axi_bresp,
  input  logic               m_axi_bvalid,
  output logic               m_axi_bready,
  output logic [ADDR_W-1:0]  m_axi_araddr,
  output logic [2:0]         m_axi_arprot,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [DATA_W-1:0]  m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready,
  output logic [3:0]         dbg_state_o
);

  localparam int OP_LSB = ENT_ADDR_LSB + ADDR_W;
  localparam int PCW    = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_TIMEOUT);

  state_e              state_q, state_d;
  logic [TBL_AW-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [PCW-1:0]      poll_cnt_q, poll_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                err_q, err_d;
  logic [TBL_AW-1:0]   err_idx_q, err_idx_d;

  logic                aw_hs, w_hs, rd_match;
  logic [PCW-1:0]      poll_inc;
  logic [WAIT_W-1:0]   tbl_wait;
  op_e                 tbl_op;

  assign aw_hs    = m_axi_awvalid && m_axi_awready;
  assign w_hs     = m_axi_wvalid && m_axi_wready;
  assign rd_match = ((m_axi_rdata & mask_q) == (data_q & mask_q));
  assign poll_inc = poll_cnt_q + 1'b1;
  assign tbl_wait = tbl_data_i[ENT_DATA_LSB +: WAIT_W];
  assign tbl_op   = op_e'(tbl_data_i[OP_LSB +: 2]);

  // Next-state logic: table walk, AXI request/response sequencing and error capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    poll_cnt_d = poll_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        addr_d     = tbl_data_i[ENT_ADDR_LSB +: ADDR_W];
        data_d     = tbl_data_i[ENT_DATA_LSB +: DATA_W];
        mask_d     = tbl_data_i[ENT_MASK_LSB +: DATA_W];
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        poll_cnt_d = '0;
        wait_cnt_d = tbl_wait;
        case (tbl_op)
          OP_WRITE: state_d = ST_WR_REQ;
          OP_POLL:  state_d = ST_RD_REQ;
          OP_WAIT:  state_d = (tbl_wait == '0) ? ST_NEXT : ST_WAIT;
          default:  state_d = ST_FINISH;
        endcase
      end
      ST_WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RSP;
      end
      ST_WR_RSP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_OKAY) begin
            state_d   = ST_ERR;
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_RD_REQ: begin
        if (m_axi_arready) state_d = ST_RD_RSP;
      end
      ST_RD_RSP: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != AXI_OKAY) begin
            state_d   = ST_ERR;
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end else if (rd_match) begin
            state_d = ST_NEXT;
          end else begin
            poll_cnt_d = poll_inc;
            if (poll_inc == POLL_MAX) begin
              state_d   = ST_ERR;
              err_d     = 1'b1;
              err_idx_d = idx_q;
            end else begin
              state_d = ST_RD_REQ;
            end
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        if (wait_cnt_q == WAIT_W'(1)) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        // The last table slot ends the sequence rather than wrapping to 0.
        if (idx_q == '1) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      poll_cnt_q <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      poll_cnt_q <= poll_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  // Outputs decode directly from registered state, so reset clears them on the next edge.
  assign m_axi_awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
  assign m_axi_bready  = (state_q == ST_WR_RSP);
  assign m_axi_arvalid = (state_q == ST_RD_REQ);
  assign m_axi_rready  = (state_q == ST_RD_RSP);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = 1'b1;
  assign busy_o        = !((state_q == ST_IDLE) || (state_q == ST_FINISH) || (state_q == ST_ERR));
  assign done_o        = (state_q == ST_FINISH) || (state_q == ST_ERR);
  assign err_o         = err_q;
  assign err_idx_o     = err_idx_q;
  assign tbl_addr_o    = idx_q;
  assign dbg_state_o   = state_q;

endmodule
